// File: rtl/periph_sequencer.sv
// periph_sequencer: bus-master sequencer that pushes one operator byte to a
// register-mapped UART channel, polls for TX completion and optionally waits
// for a reply byte, which is shown on the LEDs. All outputs are registered,
// decoded from the next state so they line up with the state they belong to.
module periph_sequencer #(
    parameter int N_CH    = 2,
    parameter int DATA_W  = 8,
    parameter int REG_W   = 32,
    parameter int TIMEOUT = 100000,
    parameter int WAIT_RX = 1,
    localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    send_i,
    input  logic [CH_W-1:0]         ch_sel_i,
    input  logic [DATA_W-1:0]       dato_i,
    output logic [N_CH-1:0]         wr_o,
    output logic                    reg_sel_o,
    output logic                    addr_o,
    output logic [REG_W-1:0]        entrada_o,
    input  logic [N_CH*REG_W-1:0]   salida_i,
    output logic [DATA_W-1:0]       leds_o,
    output logic                    busy_o,
    output logic                    timeout_o
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE, WR_DATA, WR_CTRL, POLL_TX, POLL_RX, RD_DATA, CLR_RX
    } state_t;

    state_t              state_reg, state_next;
    logic [CH_W-1:0]     ch_reg, ch_next;
    logic [DATA_W-1:0]   dato_reg, dato_next;
    logic [CNT_W-1:0]    cnt_reg, cnt_next;
    logic [N_CH-1:0]     wr_reg, wr_next;
    logic                wr_en_next;
    logic                reg_sel_reg, reg_sel_next;
    logic                addr_reg, addr_next;
    logic [REG_W-1:0]    entrada_reg, entrada_next;
    logic [DATA_W-1:0]   leds_reg, leds_next;
    logic                busy_reg;
    logic                timeout_reg, timeout_next;

    logic [REG_W-1:0]    chan_word [N_CH];
    logic [REG_W-1:0]    sel_word;
    logic                unused_sel_bits;

    // Split the flat read bus into per-channel words and build the one-hot strobe.
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_chan
        assign chan_word[gi] = salida_i[gi*REG_W +: REG_W];
        assign wr_next[gi]   = wr_en_next && (ch_next == CH_W'(gi));
    end

    assign sel_word        = chan_word[ch_reg];
    // Only bit0/bit1 and the low data byte matter; the rest is read but ignored.
    assign unused_sel_bits = ^sel_word;

    // Next-state, counter and registered-output decode.
    always_comb begin
        state_next   = state_reg;
        ch_next      = ch_reg;
        dato_next    = dato_reg;
        leds_next    = leds_reg;
        timeout_next = timeout_reg;

        unique case (state_reg)
            IDLE: begin
                if (send_i && (32'(ch_sel_i) < 32'(N_CH))) begin
                    ch_next      = ch_sel_i;
                    dato_next    = dato_i;
                    timeout_next = 1'b0;
                    state_next   = WR_DATA;
                end
            end
            WR_DATA: state_next = WR_CTRL;
            WR_CTRL: state_next = POLL_TX;
            POLL_TX: begin
                // First cycle in a poll state still shows the pre-write register.
                if ((cnt_reg != '0) && !sel_word[0]) begin
                    state_next = (WAIT_RX != 0) ? POLL_RX : IDLE;
                end else if (cnt_reg == CNT_W'(TIMEOUT - 1)) begin
                    timeout_next = 1'b1;
                    state_next   = IDLE;
                end
            end
            POLL_RX: begin
                if ((cnt_reg != '0) && sel_word[1]) begin
                    state_next = RD_DATA;
                end else if (cnt_reg == CNT_W'(TIMEOUT - 1)) begin
                    timeout_next = 1'b1;
                    state_next   = IDLE;
                end
            end
            RD_DATA: begin
                if (cnt_reg != '0) begin
                    leds_next  = sel_word[DATA_W-1:0];
                    state_next = CLR_RX;
                end
            end
            CLR_RX:  state_next = IDLE;
            default: state_next = IDLE;
        endcase

        // Cycles spent in the current state; restarts on every state change.
        if ((state_next == state_reg) && (state_reg != IDLE)) begin
            cnt_next = cnt_reg + 1'b1;
        end else begin
            cnt_next = '0;
        end

        wr_en_next   = 1'b0;
        reg_sel_next = 1'b0;
        addr_next    = 1'b0;
        entrada_next = entrada_reg;
        unique case (state_next)
            WR_DATA: begin
                wr_en_next   = 1'b1;
                reg_sel_next = 1'b1;
                entrada_next = REG_W'(dato_next);
            end
            WR_CTRL: begin
                wr_en_next   = 1'b1;
                entrada_next = REG_W'(1);
            end
            RD_DATA: begin
                reg_sel_next = 1'b1;
                addr_next    = 1'b1;
            end
            CLR_RX: begin
                wr_en_next   = 1'b1;
                entrada_next = '0;
            end
            default: ;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            ch_reg      <= '0;
            dato_reg    <= '0;
            cnt_reg     <= '0;
            wr_reg      <= '0;
            reg_sel_reg <= 1'b0;
            addr_reg    <= 1'b0;
            entrada_reg <= '0;
            leds_reg    <= '0;
            busy_reg    <= 1'b0;
            timeout_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            ch_reg      <= ch_next;
            dato_reg    <= dato_next;
            cnt_reg     <= cnt_next;
            wr_reg      <= wr_next;
            reg_sel_reg <= reg_sel_next;
            addr_reg    <= addr_next;
            entrada_reg <= entrada_next;
            leds_reg    <= leds_next;
            busy_reg    <= (state_next != IDLE);
            timeout_reg <= timeout_next;
        end
    end

    assign wr_o      = wr_reg;
    assign reg_sel_o = reg_sel_reg;
    assign addr_o    = addr_reg;
    assign entrada_o = entrada_reg;
    assign leds_o    = leds_reg;
    assign busy_o    = busy_reg;
    assign timeout_o = timeout_reg;

endmodule

// File: tb/tb_periph_sequencer.sv
// Bench for periph_sequencer: two instances (2 channels with RX wait, 3 channels
// without) each driving a small registered-read UART register model.
module tb_periph_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // ---------------- instance A: N_CH=2, WAIT_RX=1, TIMEOUT=50
    logic        rst_a, send_a;
    logic        ch_a;
    logic [7:0]  dato_a, leds_a;
    logic [1:0]  wr_a;
    logic        reg_sel_a, addr_a, busy_a, timeout_a;
    logic [31:0] entrada_a;
    logic [63:0] salida_a;

    periph_sequencer #(.N_CH(2), .DATA_W(8), .REG_W(32), .TIMEOUT(50), .WAIT_RX(1)) dut_a (
        .clk(clk), .rst(rst_a), .send_i(send_a), .ch_sel_i(ch_a), .dato_i(dato_a),
        .wr_o(wr_a), .reg_sel_o(reg_sel_a), .addr_o(addr_a), .entrada_o(entrada_a),
        .salida_i(salida_a), .leds_o(leds_a), .busy_o(busy_a), .timeout_o(timeout_a)
    );

    // ---------------- instance B: N_CH=3, WAIT_RX=0, TIMEOUT=50
    logic        rst_b, send_b;
    logic [1:0]  ch_b;
    logic [7:0]  dato_b, leds_b;
    logic [2:0]  wr_b;
    logic        reg_sel_b, addr_b, busy_b, timeout_b;
    logic [31:0] entrada_b;
    logic [95:0] salida_b;

    periph_sequencer #(.N_CH(3), .DATA_W(8), .REG_W(32), .TIMEOUT(50), .WAIT_RX(0)) dut_b (
        .clk(clk), .rst(rst_b), .send_i(send_b), .ch_sel_i(ch_b), .dato_i(dato_b),
        .wr_o(wr_b), .reg_sel_o(reg_sel_b), .addr_o(addr_b), .entrada_o(entrada_b),
        .salida_i(salida_b), .leds_o(leds_b), .busy_o(busy_b), .timeout_o(timeout_b)
    );

    // ---------------- peripheral model controls (shared by both models)
    int         tx_delay = 0;   // cycles after send bit is set before TX finishes
    logic       tx_hang  = 1'b0; // TX never finishes
    logic       rx_en    = 1'b1; // raise new_rx when TX finishes
    logic [7:0] rx_byte  = 8'h00;

    logic [1:0]  ctrl_a [2];
    logic [7:0]  tx_a   [2];
    logic [7:0]  rx_a   [2];
    int          tcnt_a [2];
    logic [31:0] sal_a  [2];
    logic [1:0]  ctrl_b [3];
    logic [7:0]  tx_b   [3];
    int          tcnt_b [3];
    logic [31:0] sal_b  [3];

    int wr0_cnt_a = 0, clr_cnt_a = 0, wr_cnt_b = 0, rdrx_cnt_b = 0;

    assign salida_a = {sal_a[1], sal_a[0]};
    assign salida_b = {sal_b[2], sal_b[1], sal_b[0]};

    // Model A: control/TX/RX registers, read data registered one cycle late.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst_a) begin
                ctrl_a[k] <= 2'b00; tx_a[k] <= 8'h00; rx_a[k] <= 8'h00;
                tcnt_a[k] <= 0;     sal_a[k] <= 32'h0;
            end else begin
                if (wr_a[k]) begin
                    if (reg_sel_a && !addr_a) tx_a[k] <= entrada_a[7:0];
                    else if (!reg_sel_a) begin ctrl_a[k] <= entrada_a[1:0]; tcnt_a[k] <= 0; end
                end else if (ctrl_a[k][0] && !tx_hang) begin
                    if (tcnt_a[k] >= tx_delay) begin
                        ctrl_a[k] <= {rx_en, 1'b0};
                        rx_a[k]   <= rx_byte;
                    end else tcnt_a[k] <= tcnt_a[k] + 1;
                end
                sal_a[k] <= reg_sel_a ? (addr_a ? {24'h0, rx_a[k]} : {24'h0, tx_a[k]})
                                      : {30'h0, ctrl_a[k]};
            end
        end
        if (!rst_a && wr_a[0]) wr0_cnt_a <= wr0_cnt_a + 1;
        if (!rst_a && wr_a[1] && !reg_sel_a && entrada_a == 32'h0) clr_cnt_a <= clr_cnt_a + 1;
    end

    // Model B: same control/TX behaviour, no RX side needed.
    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (rst_b) begin
                ctrl_b[k] <= 2'b00; tx_b[k] <= 8'h00; tcnt_b[k] <= 0; sal_b[k] <= 32'h0;
            end else begin
                if (wr_b[k]) begin
                    if (reg_sel_b && !addr_b) tx_b[k] <= entrada_b[7:0];
                    else if (!reg_sel_b) begin ctrl_b[k] <= entrada_b[1:0]; tcnt_b[k] <= 0; end
                end else if (ctrl_b[k][0] && !tx_hang) begin
                    if (tcnt_b[k] >= tx_delay) ctrl_b[k] <= 2'b00;
                    else tcnt_b[k] <= tcnt_b[k] + 1;
                end
                sal_b[k] <= reg_sel_b ? {24'h0, tx_b[k]} : {30'h0, ctrl_b[k]};
            end
        end
        if (!rst_b && (|wr_b)) wr_cnt_b <= wr_cnt_b + 1;
        if (!rst_b && reg_sel_b && addr_b) rdrx_cnt_b <= rdrx_cnt_b + 1;
    end

    // ---------------- tests
    task automatic test_reset();
        rst_a = 1'b1; rst_b = 1'b1;
        send_a = 1'b0; ch_a = 1'b0; dato_a = 8'h00;
        send_b = 1'b0; ch_b = 2'd0; dato_b = 8'h00;
        repeat (3) @(negedge clk);
        checks++;
        if ({wr_a, reg_sel_a, addr_a, busy_a, timeout_a} !== 6'b0) begin
            errors++; $display("FAIL reset_ctrl_a got %b want 000000", {wr_a, reg_sel_a, addr_a, busy_a, timeout_a});
        end
        checks++;
        if ({entrada_a, leds_a} !== 40'h0) begin
            errors++; $display("FAIL reset_data_a got %h want 0", {entrada_a, leds_a});
        end
        checks++;
        if ({wr_b, reg_sel_b, addr_b, busy_b, timeout_b, entrada_b, leds_b} !== 47'h0) begin
            errors++; $display("FAIL reset_b got %h want 0", {wr_b, reg_sel_b, addr_b, busy_b, timeout_b, entrada_b, leds_b});
        end
        rst_a = 1'b0; rst_b = 1'b0;
        @(negedge clk);
        $display("reset: done");
    endtask

    task automatic test_write_seq();
        tx_delay = 10; tx_hang = 1'b0; rx_en = 1'b1; rx_byte = 8'h3C;
        send_a = 1'b1; ch_a = 1'b1; dato_a = 8'hA5;
        @(negedge clk);
        send_a = 1'b0;
        checks++;
        if ({wr_a, reg_sel_a, addr_a, busy_a} !== 5'b10101 || entrada_a !== 32'h0000_00A5) begin
            errors++; $display("FAIL wr_data got wr=%b rs=%b ad=%b busy=%b ent=%h want wr=10 rs=1 ad=0 busy=1 ent=000000a5",
                               wr_a, reg_sel_a, addr_a, busy_a, entrada_a);
        end
        @(negedge clk);
        checks++;
        if ({wr_a, reg_sel_a} !== 3'b100 || entrada_a !== 32'h0000_0001) begin
            errors++; $display("FAIL wr_ctrl got wr=%b rs=%b ent=%h want wr=10 rs=0 ent=00000001", wr_a, reg_sel_a, entrada_a);
        end
        @(negedge clk);
        checks++;
        if (wr_a !== 2'b00 || reg_sel_a !== 1'b0) begin
            errors++; $display("FAIL poll_tx_idle_bus got wr=%b rs=%b want wr=00 rs=0", wr_a, reg_sel_a);
        end
        $display("write_seq: ch1 dato=a5 wr=%b", wr_a);
    endtask

    task automatic test_rx_path();
        int n = 0;
        while (busy_a && n < 200) begin n++; @(negedge clk); end
        checks++;
        if (busy_a !== 1'b0) begin errors++; $display("FAIL rx_done_timeout got busy=%b want 0", busy_a); end
        checks++;
        if (leds_a !== 8'h3C) begin errors++; $display("FAIL rx_leds got %h want 3c", leds_a); end
        checks++;
        if (clr_cnt_a !== 1) begin errors++; $display("FAIL rx_clr_writes got %0d want 1", clr_cnt_a); end
        checks++;
        if (wr0_cnt_a !== 0 || timeout_a !== 1'b0) begin
            errors++; $display("FAIL rx_side_effects got wr0=%0d to=%b want 0 0", wr0_cnt_a, timeout_a);
        end
        $display("rx_path: leds=%h after %0d cycles", leds_a, n);
    endtask

    task automatic test_timeout();
        int n = 0;
        tx_hang = 1'b1;
        send_a = 1'b1; ch_a = 1'b0; dato_a = 8'h11;
        @(negedge clk);
        send_a = 1'b0;
        // WR_DATA + WR_CTRL + 50 cycles in POLL_TX
        while (busy_a && n < 200) begin n++; @(negedge clk); end
        checks++;
        if (n !== 52) begin errors++; $display("FAIL timeout_busy_len got %0d want 52", n); end
        checks++;
        if (timeout_a !== 1'b1) begin errors++; $display("FAIL timeout_flag got %b want 1", timeout_a); end
        checks++;
        if (leds_a !== 8'h3C) begin errors++; $display("FAIL timeout_leds got %h want 3c", leds_a); end
        repeat (3) @(negedge clk);
        checks++;
        if (timeout_a !== 1'b1) begin errors++; $display("FAIL timeout_sticky got %b want 1", timeout_a); end
        rx_byte = 8'h5A; tx_delay = 0; tx_hang = 1'b0;
        send_a = 1'b1; ch_a = 1'b0; dato_a = 8'h22;
        @(negedge clk);
        send_a = 1'b0;
        checks++;
        if (timeout_a !== 1'b0) begin errors++; $display("FAIL timeout_clear got %b want 0", timeout_a); end
        n = 0;
        while (busy_a && n < 200) begin n++; @(negedge clk); end
        checks++;
        if (leds_a !== 8'h5A || busy_a !== 1'b0) begin
            errors++; $display("FAIL timeout_recover got leds=%h busy=%b want 5a 0", leds_a, busy_a);
        end
        $display("timeout: flagged, then recovered leds=%h", leds_a);
    endtask

    task automatic test_ignore();
        int n = 0;
        int wr0_before;
        int wrb_before;
        logic busy_seen = 1'b0;
        wr0_before = wr0_cnt_a;
        tx_delay = 10; rx_byte = 8'h66;
        send_a = 1'b1; ch_a = 1'b1; dato_a = 8'h44;
        @(negedge clk);
        send_a = 1'b0;
        repeat (3) @(negedge clk);
        send_a = 1'b1; ch_a = 1'b0; dato_a = 8'hFF;
        @(negedge clk);
        send_a = 1'b0;
        while (busy_a && n < 200) begin n++; @(negedge clk); end
        checks++;
        if (wr0_cnt_a !== wr0_before) begin errors++; $display("FAIL ignore_busy_wr0 got %0d want %0d", wr0_cnt_a, wr0_before); end
        checks++;
        if (tx_a[1] !== 8'h44 || leds_a !== 8'h66) begin
            errors++; $display("FAIL ignore_busy_data got tx=%h leds=%h want 44 66", tx_a[1], leds_a);
        end
        wrb_before = wr_cnt_b;
        send_b = 1'b1; ch_b = 2'd3; dato_b = 8'h12;
        @(negedge clk);
        send_b = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (busy_b) busy_seen = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (busy_seen !== 1'b0 || wr_cnt_b !== wrb_before) begin
            errors++; $display("FAIL ignore_bad_ch got busy=%b writes=%0d want 0 %0d", busy_seen, wr_cnt_b, wrb_before);
        end
        $display("ignore: busy pulse and ch_sel=3 dropped");
    endtask

    task automatic test_no_rx();
        int n = 0;
        int wrb_before;
        wrb_before = wr_cnt_b;
        tx_delay = 0;
        // send_i driven before edge 1; TX engine clears send as soon as the
        // control write lands, which a registered read shows two cycles later.
        send_b = 1'b1; ch_b = 2'd2; dato_b = 8'h77;
        @(negedge clk);
        send_b = 1'b0;
        while (busy_b && n < 200) begin n++; @(negedge clk); end
        checks++;
        if (n !== 5) begin errors++; $display("FAIL norx_busy_len got %0d want 5", n); end
        checks++;
        if (rdrx_cnt_b !== 0) begin errors++; $display("FAIL norx_rx_reads got %0d want 0", rdrx_cnt_b); end
        checks++;
        if (tx_b[2] !== 8'h77 || wr_cnt_b !== wrb_before + 2) begin
            errors++; $display("FAIL norx_writes got tx=%h writes=%0d want 77 %0d", tx_b[2], wr_cnt_b, wrb_before + 2);
        end
        $display("no_rx: busy %0d cycles tx=%h", n, tx_b[2]);
    endtask

    task automatic test_reset_mid();
        int n = 0;
        rx_en = 1'b0; tx_delay = 2;
        send_a = 1'b1; ch_a = 1'b1; dato_a = 8'h09;
        @(negedge clk);
        send_a = 1'b0;
        repeat (12) @(negedge clk);
        checks++;
        if (busy_a !== 1'b1) begin errors++; $display("FAIL midrst_pre_busy got %b want 1", busy_a); end
        rst_a = 1'b1;
        @(negedge clk);
        checks++;
        if ({wr_a, reg_sel_a, addr_a, busy_a, timeout_a, entrada_a, leds_a} !== 46'h0) begin
            errors++; $display("FAIL midrst_outputs got %h want 0", {wr_a, reg_sel_a, addr_a, busy_a, timeout_a, entrada_a, leds_a});
        end
        rst_a = 1'b0; rx_en = 1'b1; rx_byte = 8'hC3;
        @(negedge clk);
        send_a = 1'b1; ch_a = 1'b1; dato_a = 8'h0A;
        @(negedge clk);
        send_a = 1'b0;
        while (busy_a && n < 200) begin n++; @(negedge clk); end
        checks++;
        if (leds_a !== 8'hC3 || busy_a !== 1'b0 || timeout_a !== 1'b0) begin
            errors++; $display("FAIL midrst_recover got leds=%h busy=%b to=%b want c3 0 0", leds_a, busy_a, timeout_a);
        end
        $display("reset_mid: recovered leds=%h", leds_a);
    endtask

    initial begin
        test_reset();
        test_write_seq();
        test_rx_path();
        test_timeout();
        test_ignore();
        test_no_rx();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
